// File: rtl/cs_pkg.sv
// Shared types and constants for the CS approximate-averaging front end.
package cs_pkg;
   localparam int SAMPLE_W = 8;
   localparam int Y_W      = 10;
   localparam int CS_N     = 9;

   typedef enum logic {PREFILL, STREAM} feed_state_t;
endpackage

// File: rtl/cs_sample_fifo.sv
// Circular sample buffer with natural-wrap pointers and an occupancy counter.
module cs_sample_fifo
   import cs_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_valid,
   input  logic [SAMPLE_W-1:0]      i_data,
   input  logic                     i_pop,
   output logic                     o_ready,
   output logic [SAMPLE_W-1:0]      o_head,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [SAMPLE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]       r_wptr, r_rptr;
   logic [LW-1:0]       r_count;
   logic                w_push, w_pop;

   assign o_ready = !reset && (r_count != LW'(DEPTH));
   assign w_push  = i_valid && o_ready;
   // Pop reads only the registered head, so a same-cycle push never falls through.
   assign w_pop   = i_pop && (r_count != '0);
   assign o_head  = r_mem[r_rptr];
   assign o_level = r_count;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/cs_sample_feeder.sv
// Prefills a sample FIFO, then streams one sample per clock into CS.
// Optional CS_FEED_UNDERFLOW_CNT_EN adds a saturating starvation counter uf_count.
module cs_sample_feeder
   import cs_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int PREFILL = 4,
   parameter int N       = CS_N
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [SAMPLE_W-1:0]      in_data,
   output logic                     in_ready,
   output logic [SAMPLE_W-1:0]      X,
   output logic                     cs_reset,
   output logic                     y_valid,
   output logic                     underflow,
   output logic [$clog2(DEPTH):0]   level
`ifdef CS_FEED_UNDERFLOW_CNT_EN
   ,
   output logic [7:0]               uf_count
`endif
);
   localparam int IW = $clog2(N + 1);

   cs_pkg::feed_state_t r_state;
   logic [SAMPLE_W-1:0] r_x;
   logic                r_cs_reset, r_y_valid, r_underflow;
   logic [IW-1:0]       r_issued;
   logic [SAMPLE_W-1:0] w_head;
   logic                w_push, w_nonempty, w_start, w_pop;

   cs_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_valid (in_valid),
      .i_data  (in_data),
      .i_pop   (w_pop),
      .o_ready (in_ready),
      .o_head  (w_head),
      .o_level (level)
   );

   assign w_push     = in_valid && in_ready;
   assign w_nonempty = (level != '0);
   // Start counts this cycle's push, but still needs a real head to present.
   assign w_start    = (r_state == cs_pkg::PREFILL) && w_nonempty &&
                       ((int'(level) + int'(w_push)) >= PREFILL);
   assign w_pop      = w_start || ((r_state == cs_pkg::STREAM) && w_nonempty);

   assign X         = r_x;
   assign cs_reset  = r_cs_reset;
   assign y_valid   = r_y_valid;
   assign underflow = r_underflow;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= cs_pkg::PREFILL;
         r_x         <= '0;
         r_cs_reset  <= 1'b1;
         r_y_valid   <= 1'b0;
         r_underflow <= 1'b0;
         r_issued    <= '0;
      end else begin
         r_underflow <= (r_state == cs_pkg::STREAM) && !w_nonempty;
         if (w_start) begin
            r_state    <= cs_pkg::STREAM;
            r_cs_reset <= 1'b0;
         end
         if (w_pop) begin
            r_x <= w_head;
            if (r_issued != IW'(N)) r_issued <= r_issued + 1'b1;
            if (r_issued >= IW'(N - 1)) r_y_valid <= 1'b1;
         end
      end
   end

`ifdef CS_FEED_UNDERFLOW_CNT_EN
   logic [7:0] r_uf_count;
   assign uf_count = r_uf_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_uf_count <= '0;
      else if ((r_state == cs_pkg::STREAM) && !w_nonempty && (r_uf_count != 8'hFF))
         r_uf_count <= r_uf_count + 1'b1;
   end
`endif
endmodule

// File: tb/tb_cs_sample_feeder.sv
// Scoreboard bench: two feeders (PREFILL 4 and 16) against a queue-based reference model.
module tb_cs_sample_feeder;
   localparam int DEPTH = 16;
   localparam int NW    = 9;

   typedef struct {
      int x;
      int csr;
      int yv;
      int uf;
      int lvl;
      int ufc;
   } rec_t;

   logic       clk = 1'b0;
   logic       reset, in_valid;
   logic [7:0] in_data;
   logic       rdy [2];
   logic [7:0] xo  [2];
   logic       csr [2];
   logic       yv  [2];
   logic       uf  [2];
   logic [4:0] lvl [2];
`ifdef CS_FEED_UNDERFLOW_CNT_EN
   logic [7:0] ufc [2];
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cs_sample_feeder #(.DEPTH(DEPTH), .PREFILL(4), .N(NW)) u_dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[0]), .X(xo[0]), .cs_reset(csr[0]), .y_valid(yv[0]),
      .underflow(uf[0]), .level(lvl[0])
`ifdef CS_FEED_UNDERFLOW_CNT_EN
      , .uf_count(ufc[0])
`endif
   );

   cs_sample_feeder #(.DEPTH(DEPTH), .PREFILL(16), .N(NW)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[1]), .X(xo[1]), .cs_reset(csr[1]), .y_valid(yv[1]),
      .underflow(uf[1]), .level(lvl[1])
`ifdef CS_FEED_UNDERFLOW_CNT_EN
      , .uf_count(ufc[1])
`endif
   );

   // Reference model: FIFO as a queue, streaming as a flag, counts as plain ints.
   int   mq    [2][$];
   rec_t exp_q [2][$];
   bit   m_strm [2];
   int   m_x [2], m_csr [2], m_yv [2], m_uf [2], m_iss [2], m_ufc [2];

   always @(posedge clk) begin : model
      rec_t r;
      bit   push, pop;
      int   pf;
      for (int k = 0; k < 2; k++) begin
         pf = (k == 0) ? 4 : 16;
         if (reset) begin
            mq[k].delete();
            m_strm[k] = 1'b0;
            m_x[k] = 0; m_csr[k] = 1; m_yv[k] = 0; m_uf[k] = 0; m_iss[k] = 0; m_ufc[k] = 0;
         end else begin
            push = in_valid && (mq[k].size() < DEPTH);
            pop  = 1'b0;
            m_uf[k] = 0;
            if (!m_strm[k]) begin
               if (mq[k].size() > 0 && (mq[k].size() + int'(push)) >= pf) begin
                  pop = 1'b1;
                  m_strm[k] = 1'b1;
                  m_csr[k] = 0;
               end
            end else if (mq[k].size() > 0) begin
               pop = 1'b1;
            end else begin
               m_uf[k] = 1;
            end
            if (pop) begin
               m_x[k] = mq[k].pop_front();
               if (m_iss[k] < NW) m_iss[k]++;
            end
            if (push) mq[k].push_back(int'(in_data));
            m_yv[k] = (m_iss[k] >= NW) ? 1 : 0;
            if (m_uf[k] == 1 && m_ufc[k] < 255) m_ufc[k]++;
         end
         r.x = m_x[k]; r.csr = m_csr[k]; r.yv = m_yv[k]; r.uf = m_uf[k];
         r.lvl = mq[k].size(); r.ufc = m_ufc[k];
         exp_q[k].push_back(r);
      end
   end

   task automatic chk(input string nm, input int k, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s lane%0d: got %0d expected %0d at %0t", nm, k, act, exp_v, $time);
      end
   endtask

   always @(posedge clk) begin : monitor
      rec_t e;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (exp_q[k].size() == 0) begin
            chk("scoreboard_empty", k, 0, 1);
         end else begin
            e = exp_q[k].pop_front();
            chk("X",         k, int'(xo[k]),  e.x);
            chk("cs_reset",  k, int'(csr[k]), e.csr);
            chk("y_valid",   k, int'(yv[k]),  e.yv);
            chk("underflow", k, int'(uf[k]),  e.uf);
            chk("level",     k, int'(lvl[k]), e.lvl);
            chk("in_ready",  k, int'(rdy[k]), (!reset && e.lvl != DEPTH) ? 1 : 0);
`ifdef CS_FEED_UNDERFLOW_CNT_EN
            chk("uf_count",  k, int'(ufc[k]), e.ufc);
`endif
         end
      end
   end

   initial begin
      int dens;
      reset = 1'b1; in_valid = 1'b0; in_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      // Consecutive ramp: exercises prefill release, X stepping and y_valid.
      for (int v = 1; v <= 40; v++) begin
         in_valid = 1'b1; in_data = 8'(v);
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (25) @(negedge clk);
      in_valid = 1'b1; in_data = 8'd50;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      // Mid-stream reset pulse with data in flight.
      for (int v = 0; v < 6; v++) begin
         in_valid = 1'b1; in_data = 8'($urandom);
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      // Saturated producer for both prefill depths.
      for (int v = 0; v < 40; v++) begin
         in_valid = 1'b1; in_data = 8'($urandom);
         @(negedge clk);
      end
      // Long starvation to drive the underflow counter into saturation.
      in_valid = 1'b0;
      repeat (300) @(negedge clk);
      for (int seg = 0; seg < 12; seg++) begin
         dens = $urandom_range(0, 4);
         for (int c = 0; c < 120; c++) begin
            in_valid = ($urandom_range(0, 3) < dens);
            in_data  = 8'($urandom);
            reset    = ($urandom_range(0, 299) == 0);
            @(negedge clk);
         end
      end
      reset = 1'b0; in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
